// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain clock/data enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_HOLD = 25,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ack_ok,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);
  localparam int CW = $clog2(INHIBIT_CYCLES > START_HOLD ? INHIBIT_CYCLES : START_HOLD) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int FW = $clog2(FILTER_LEN) + 1;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic [FW-1:0] fcnt;
  logic filt, filt_d, fall, data_sync, timed_out;
  logic [8:0] frame, frame_n;
  logic [9:0] frame_ext;
  logic [3:0] bit_idx, bit_idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic ack_n, done_n, err_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      fcnt <= '0;
      filt <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2clk_in};
      dat_s <= {dat_s[0], ps2dat_in};
      filt_d <= filt;
      if (clk_s[1] == filt)
        fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        fcnt <= '0;
      end else
        fcnt <= fcnt + 1'b1;
    end
  assign data_sync = dat_s[1];
  assign fall = filt_d & ~filt;
  assign timed_out = tcnt == TW'(TIMEOUT_CYCLES - 1);
  // Index 0 is the start bit, so the line stays low until the first device edge.
  assign frame_ext = {frame, 1'b0};
  assign tx_busy = state != IDLE;
  assign rx_inhibit = tx_busy;
  assign ps2clk_oe = state == INHIBIT || state == START;
  assign ps2dat_oe = state == START || (state == SHIFT && !frame_ext[bit_idx]);
  always_comb begin
    state_n = state;
    frame_n = frame;
    bit_idx_n = bit_idx;
    cnt_n = cnt;
    tcnt_n = tcnt;
    ack_n = ack_ok;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE:
        if (tx_start) begin
          frame_n = {~^tx_data, tx_data};
          bit_idx_n = '0;
          cnt_n = '0;
          ack_n = 1'b0;
          state_n = INHIBIT;
        end
      INHIBIT: begin
        cnt_n = cnt == CW'(INHIBIT_CYCLES - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(INHIBIT_CYCLES - 1) ? START : INHIBIT;
      end
      START: begin
        cnt_n = cnt == CW'(START_HOLD - 1) ? '0 : cnt + 1'b1;
        tcnt_n = '0;
        state_n = cnt == CW'(START_HOLD - 1) ? SHIFT : START;
      end
      SHIFT:
        if (fall) begin
          bit_idx_n = bit_idx + 1'b1;
          state_n = bit_idx == 4'd9 ? ACK : SHIFT;
        end
      ACK:
        if (fall) begin
          ack_n = ~data_sync;
          state_n = WAIT_IDLE;
        end
      WAIT_IDLE:
        if (filt && data_sync) begin
          done_n = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    // Completion takes priority over a timeout landing in the same cycle.
    if (state inside {SHIFT, ACK, WAIT_IDLE}) begin
      tcnt_n = tcnt + 1'b1;
      if (timed_out && !done_n) begin
        err_n = 1'b1;
        ack_n = 1'b0;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      frame <= '0;
      bit_idx <= '0;
      cnt <= '0;
      tcnt <= '0;
      ack_ok <= 1'b0;
      tx_done <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state <= state_n;
      frame <= frame_n;
      bit_idx <= bit_idx_n;
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      ack_ok <= ack_n;
      tx_done <= done_n;
      tx_error <= err_n;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic.
- Counterpart to the existing PS/2 receive path inside sys; shares the ps2clk/ps2dat pins through open-drain pin drivers.
- Instantiated in sys, beside the keyboard receiver, in the clk domain (25 MHz).
- Asserts rx_inhibit while it owns the bus, so the receiver ignores host-driven traffic.

Parameters:
- INHIBIT_CYCLES, 2500: clock-low inhibit length in clk cycles (100 us at 25 MHz).
- START_HOLD, 25: cycles data is held low before clock is released (1 us).
- TIMEOUT_CYCLES, 375000: maximum cycles from clock release to end of transfer (15 ms).
- FILTER_LEN, 4: consecutive equal synchronized samples needed to accept a new ps2clk level.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte; sampled when tx_start is accepted.
- tx_start  in  1  single-cycle request; accepted only when tx_busy=0.
- tx_busy  out  1  high from the accept cycle until the done/error pulse.
- tx_done  out  1  one-cycle pulse when the transfer completes normally.
- ack_ok  out  1  valid on the tx_done cycle and held until the next accept: 1 = device ACK seen.
- tx_error  out  1  one-cycle pulse on timeout.
- rx_inhibit  out  1  equal to tx_busy.
- ps2clk_in  in  1  raw clock pin level (asynchronous).
- ps2dat_in  in  1  raw data pin level (asynchronous).
- ps2clk_oe  out  1  1 = pull the clock pin low.
- ps2dat_oe  out  1  1 = pull the data pin low.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; shift register 0; counters 0.
  - Reset mid-transfer releases both lines immediately (asynchronous) and emits no done/error pulse.
- Input conditioning:
  - ps2clk_in and ps2dat_in pass through 2-flop synchronizers.
  - Filtered clock changes level only after FILTER_LEN equal synchronized samples.
  - A falling edge is the cycle the filtered clock goes 1->0.
  - Data is sampled from its synchronizer output.
- Accept: in IDLE with tx_start=1:
  - Latch frame = {odd parity, tx_data}, where parity = ~^tx_data.
  - Set tx_busy=1 and bit index 0; enter INHIBIT.
  - tx_start while busy is ignored; it does not queue.
- INHIBIT:
  - ps2clk_oe=1, ps2dat_oe=0 for exactly INHIBIT_CYCLES cycles.
  - Then enter START.
- START:
  - ps2clk_oe=1, ps2dat_oe=1 (start bit 0) for START_HOLD cycles.
  - Then ps2clk_oe=0 and enter SHIFT.
  - Timeout counter clears and starts here.
- SHIFT: ps2dat_oe tracks the current bit; a bit value of 0 drives oe=1.
  - Falling edges 1..8: present data bits D0..D7, LSB first.
  - Falling edge 9: present the parity bit.
  - Falling edge 10: release data (stop bit 1) and enter ACK.
  - The data line holds START's low level until falling edge 1.
- ACK:
  - On the next falling edge, ack_ok <= ~data_sync; enter WAIT_IDLE.
- WAIT_IDLE:
  - When filtered clock=1 and data_sync=1, pulse tx_done, clear tx_busy, enter IDLE.
- Timeout:
  - In SHIFT, ACK or WAIT_IDLE, if the counter reaches TIMEOUT_CYCLES: release both lines, pulse tx_error, clear tx_busy, enter IDLE.
  - ack_ok=0 after a timeout.
  - If timeout and completion fall in the same cycle, completion wins.
- tx_done and tx_error are mutually exclusive and never asserted outside their pulse cycle.
- Clock edges seen in INHIBIT or START are ignored.
- No other lines are driven during IDLE.

Test Plan:
- Set-LEDs byte: tx_data=0xED (6 ones), with a bench device model that clocks at ~12 kHz and ACKs.
  - Bits seen at device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once with ack_ok=1; tx_busy is high for the whole frame; both oe are 0 afterwards.
- Parity sweep: 0x00 -> parity 1; 0x01 -> parity 0; 0xFF -> parity 1; 0xF3 -> parity 1.
  - Each is checked against the device model's received frame.
- Timing (INHIBIT_CYCLES=50, START_HOLD=5):
  - ps2clk_oe stays high exactly 55 cycles after accept.
  - ps2dat_oe rises at cycle 50.
- No device (lines pulled up, no clocks), with TIMEOUT_CYCLES=1000:
  - tx_error pulses exactly once, 1000 cycles after clock release.
  - tx_done never pulses; both oe are 0; tx_busy falls in the same cycle.
- Missing ACK: device leaves data high on the 11th falling edge -> tx_done pulses with ack_ok=0.
- Robustness:
  - A second tx_start during a transfer is ignored; only one frame appears.
  - A 2-cycle glitch on ps2clk_in causes no bit advance.
  - reset asserted at bit 4 -> oe=0 in the same cycle, no pulses, and the next transfer completes normally.
